mux_41_arbiter: RTL and testbench

MUX_41_ARBITER -- requirements
Module: mux_41_arbiter

---
 rtl/mux_41_arbiter.sv | 117 +++++++++++
 tb/tb_mux_41_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_41_arbiter.sv
// Round-robin 4:1 arbiter with a bounded hold time per owner, driving a 4:1 data mux
// through a registered select.
module mux_41_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] req_in,
    input  logic [3:0] A_in,
    input  logic [3:0] B_in,
    input  logic [3:0] C_in,
    input  logic [3:0] D_in,
    output logic [3:0] gnt_out,
    output logic       S0_out,
    output logic       S1_out,
    output logic [3:0] data_out,
    output logic       valid_out
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;

    logic       ownerReq;
    logic [1:0] nextPtr;
    logic [3:0] others;

    // First set bit of req at or after start, scanning cyclically upward.
    function automatic logic [1:0] pickFrom(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        pickFrom = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) pickFrom = idx;
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        ownerReq = req_in[owner_q];
        nextPtr  = owner_q + 2'd1;
        others   = req_in & ~(4'b0001 << owner_q);

        if (state_q == IDLE) begin
            if (req_in != 4'b0000) begin
                owner_d = pickFrom(req_in, ptr_q);
                state_d = GRANT;
                cnt_d   = 4'd1;
                gnt_d   = 4'b0001 << owner_d;
            end else begin
                cnt_d = 4'd0;
                gnt_d = 4'b0000;
            end
        end else if (!ownerReq) begin
            // Release hands straight over to the next requester, no idle bubble.
            ptr_d = nextPtr;
            if (req_in != 4'b0000) begin
                owner_d = pickFrom(req_in, nextPtr);
                cnt_d   = 4'd1;
                gnt_d   = 4'b0001 << owner_d;
            end else begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                gnt_d   = 4'b0000;
            end
        end else if (cnt_q < 4'(MAX_HOLD)) begin
            cnt_d = cnt_q + 4'd1;
        end else if (others != 4'b0000) begin
            ptr_d   = nextPtr;
            owner_d = pickFrom(others, nextPtr);
            cnt_d   = 4'd1;
            gnt_d   = 4'b0001 << owner_d;
        end else begin
            cnt_d = 4'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt_out   = gnt_q;
    assign S0_out    = owner_q[0];
    assign S1_out    = owner_q[1];
    assign valid_out = (state_q == GRANT) && req_in[owner_q];

    // Select stays on the last owner while idle, so data keeps following it.
    always_comb begin
        case (owner_q)
            2'd0:    data_out = A_in;
            2'd1:    data_out = B_in;
            2'd2:    data_out = C_in;
            default: data_out = D_in;
        endcase
    end

endmodule

// File: tb/tb_mux_41_arbiter.sv
// Testbench for mux_41_arbiter: directed vector table, corner-case sequences and
// random traffic, on a MAX_HOLD=4 and a MAX_HOLD=1 instance sharing the same inputs.
module tb_mux_41_arbiter;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic [3:0] req_in = 4'b0000;
    logic [3:0] word [4];

    logic [3:0] gnt0, gnt1, data0, data1;
    logic       s00, s10, s01, s11, valid0, valid1;

    int nChecks = 0;
    int nFail   = 0;

    int mBusy [2];
    int mOwner[2];
    int mPtr  [2];
    int mCnt  [2];

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
    } vec_t;
    vec_t vecs[$];

    always #5 clk_in = ~clk_in;

    mux_41_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in),
        .A_in(word[0]), .B_in(word[1]), .C_in(word[2]), .D_in(word[3]),
        .gnt_out(gnt0), .S0_out(s00), .S1_out(s10), .data_out(data0), .valid_out(valid0)
    );

    mux_41_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in),
        .A_in(word[0]), .B_in(word[1]), .C_in(word[2]), .D_in(word[3]),
        .gnt_out(gnt1), .S0_out(s01), .S1_out(s11), .data_out(data1), .valid_out(valid1)
    );

    function automatic int firstFrom(input logic [3:0] req, input int start);
        for (int off = 0; off < 4; off++)
            if (req[(start + off) % 4]) return (start + off) % 4;
        return 0;
    endfunction

    // Reference arbiter: round-robin from a pointer, bounded hold, handover on release.
    task automatic modelStep(input int i);
        int         maxHold;
        logic [3:0] others;
        maxHold = (i == 0) ? 4 : 1;
        if (rst_in) begin
            mBusy[i] = 0; mOwner[i] = 0; mPtr[i] = 0; mCnt[i] = 0;
        end else if (mBusy[i] == 0) begin
            if (req_in != 0) begin
                mOwner[i] = firstFrom(req_in, mPtr[i]);
                mBusy[i] = 1;
                mCnt[i] = 1;
            end
        end else if (!req_in[mOwner[i]]) begin
            mPtr[i] = (mOwner[i] + 1) % 4;
            if (req_in != 0) begin
                mOwner[i] = firstFrom(req_in, mPtr[i]);
                mCnt[i] = 1;
            end else begin
                mBusy[i] = 0;
                mCnt[i] = 0;
            end
        end else if (mCnt[i] < maxHold) begin
            mCnt[i] = mCnt[i] + 1;
        end else begin
            others = req_in;
            others[mOwner[i]] = 1'b0;
            if (others != 0) begin
                mPtr[i] = (mOwner[i] + 1) % 4;
                mOwner[i] = firstFrom(others, mPtr[i]);
            end
            mCnt[i] = 1;
        end
    endtask

    task automatic checkVal(input string name, input logic [7:0] actual, input logic [7:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic checkOutput(input int i);
        logic [3:0] expGnt;
        logic       expValid;
        expGnt   = (mBusy[i] != 0) ? (4'b0001 << mOwner[i]) : 4'b0000;
        expValid = (mBusy[i] != 0) && req_in[mOwner[i]];
        if (i == 0) begin
            checkVal("gnt_h4",   8'(gnt0),        8'(expGnt));
            checkVal("sel_h4",   8'({s10, s00}),  8'(mOwner[i]));
            checkVal("data_h4",  8'(data0),       8'(word[mOwner[i]]));
            checkVal("valid_h4", 8'(valid0),      8'(expValid));
        end else begin
            checkVal("gnt_h1",   8'(gnt1),        8'(expGnt));
            checkVal("sel_h1",   8'({s11, s01}),  8'(mOwner[i]));
            checkVal("data_h1",  8'(data1),       8'(word[mOwner[i]]));
            checkVal("valid_h1", 8'(valid1),      8'(expValid));
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] q);
        @(negedge clk_in);
        rst_in = r;
        req_in = q;
    endtask

    task automatic tick();
        @(posedge clk_in);
        modelStep(0);
        modelStep(1);
        #1;
    endtask

    function automatic void addVec(input logic r, input logic [3:0] q, input logic [3:0] g,
                                   input logic [1:0] s, input logic v);
        vec_t e;
        e.rst = r; e.req = q; e.gnt = g; e.sel = s; e.valid = v;
        vecs.push_back(e);
    endfunction

    initial begin
        word[0] = 4'd1; word[1] = 4'd2; word[2] = 4'd3; word[3] = 4'd4;
        for (int i = 0; i < 2; i++) begin
            mBusy[i] = 0; mOwner[i] = 0; mPtr[i] = 0; mCnt[i] = 0;
        end

        // Expected values for the MAX_HOLD=4 instance, worked out by hand.
        addVec(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        addVec(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
        addVec(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
        addVec(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        for (int k = 0; k < 17; k++)
            addVec(1'b0, 4'b1111, 4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4), 1'b1);
        addVec(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        addVec(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1);
        addVec(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1);
        addVec(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
        addVec(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0);
        addVec(1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1);

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].rst, vecs[n].req);
            tick();
            checkVal("vecGnt",   8'(gnt0),       8'(vecs[n].gnt));
            checkVal("vecSel",   8'({s10, s00}), 8'(vecs[n].sel));
            checkVal("vecData",  8'(data0),      8'(vecs[n].sel) + 8'd1);
            checkVal("vecValid", 8'(valid0),     8'(vecs[n].valid));
            checkOutput(0);
            checkOutput(1);
        end

        // Owner B drops its request mid-cycle while D waits.
        applyStimulus(1'b1, 4'b0000); tick();
        applyStimulus(1'b0, 4'b0010); tick();
        applyStimulus(1'b0, 4'b1010); tick();
        applyStimulus(1'b0, 4'b1000);
        #1;
        checkVal("dropValid", 8'(valid0), 8'd0);
        checkOutput(0);
        tick();
        checkVal("dropGnt", 8'(gnt0), 8'b1000);
        checkVal("dropSel", 8'({s10, s00}), 8'd3);

        // A lone requester is never cut off at the hold limit.
        applyStimulus(1'b1, 4'b0000); tick();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 4'b0100);
            tick();
            checkVal("soloGnt_h4", 8'(gnt0), 8'b0100);
            checkVal("soloGnt_h1", 8'(gnt1), 8'b0100);
        end

        // Reset while D owns; held requests restart from A.
        applyStimulus(1'b1, 4'b0000); tick();
        applyStimulus(1'b0, 4'b1000); tick();
        checkVal("preRstGnt", 8'(gnt0), 8'b1000);
        applyStimulus(1'b1, 4'b1111); tick();
        checkVal("rstGnt",  8'(gnt0), 8'b0000);
        checkVal("rstSel",  8'({s10, s00}), 8'd0);
        checkVal("rstValid", 8'(valid0), 8'd0);
        applyStimulus(1'b0, 4'b1111); tick();
        checkVal("postRstGnt_h4", 8'(gnt0), 8'b0001);
        checkVal("postRstGnt_h1", 8'(gnt1), 8'b0001);
        applyStimulus(1'b0, 4'b1111); tick();
        checkVal("rotateGnt_h1", 8'(gnt1), 8'b0010);
        checkOutput(0);
        checkOutput(1);

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_in);
            rst_in = ($urandom_range(0, 59) == 0);
            req_in = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3))
                                                 : 4'($urandom_range(0, 15));
            for (int w = 0; w < 4; w++) word[w] = 4'($urandom_range(0, 15));
            tick();
            checkOutput(0);
            checkOutput(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
